branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit_if.sv | 43 ++++
 rtl/branch_predict_unit.sv | 119 +++++++++++
 tb/tb_branch_predict_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Resolve/lookup bus between the execute stage and the branch predict unit.
// Statistics signals exist only when BRANCH_PREDICT_STATS_EN is defined.
interface branch_predict_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10,
  parameter int IMM_W  = 20
);
  logic              valid_in;
  logic              b;
  logic              j;
  logic [2:0]        funct3;
  logic [IMM_W-1:0]  imm;
  logic [XLEN-1:0]   op0;
  logic [XLEN-1:0]   op1;
  logic [ADDR_W-1:0] address;
  logic              pred_in;
  logic [ADDR_W-1:0] fetch_addr;
  logic              pred_taken;
  logic              valid_out;
  logic              branch;
  logic [ADDR_W-1:0] target_address;
  logic              mispredict;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [15:0]       resolved_count;
  logic [15:0]       mispredict_count;
`endif

  modport master (
    output valid_in, b, j, funct3, imm, op0, op1, address, pred_in, fetch_addr,
    input  pred_taken, valid_out, branch, target_address, mispredict
`ifdef BRANCH_PREDICT_STATS_EN
    , input resolved_count, mispredict_count
`endif
  );

  modport slave (
    input  valid_in, b, j, funct3, imm, op0, op1, address, pred_in, fetch_addr,
    output pred_taken, valid_out, branch, target_address, mispredict
`ifdef BRANCH_PREDICT_STATS_EN
    , output resolved_count, mispredict_count
`endif
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolve (1-cycle) plus a 2-bit saturating-counter BHT for fetch prediction.
// Optional resolve/mispredict statistics counters: define BRANCH_PREDICT_STATS_EN.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 10,
  parameter int IMM_W     = 20,
  parameter int BHT_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predict_unit_if.slave   bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        r_bht [BHT_DEPTH];
  logic              r_valid_out;
  logic              r_branch;
  logic [ADDR_W-1:0] r_target;
  logic              r_mispredict;

  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;
  logic              w_cond;
  logic              w_cond_valid;
  logic              w_taken;
  logic              w_mispredict;
  logic              w_bht_upd;
  logic [ADDR_W-1:0] w_target;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [1:0]        w_ctr;

  assign w_eq  = (bus.op0 == bus.op1);
  assign w_lt  = ($signed(bus.op0) < $signed(bus.op1));
  assign w_ltu = (bus.op0 < bus.op1);

  always_comb begin
    w_cond       = 1'b0;
    w_cond_valid = 1'b1;
    case (bus.funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_cond_valid = 1'b0;
    endcase
  end

  // Jump wins over a conditional branch; nothing is taken without a request.
  assign w_taken      = bus.valid_in & (bus.j | (bus.b & w_cond));
  assign w_mispredict = bus.valid_in & (bus.b | bus.j) & (w_taken != bus.pred_in);
  assign w_target     = bus.address + bus.imm[ADDR_W-1:0];
  assign w_bht_upd    = bus.valid_in & bus.b & ~bus.j & w_cond_valid;
  assign w_upd_idx    = bus.address[IDX_W-1:0];
  assign w_rd_idx     = bus.fetch_addr[IDX_W-1:0];
  assign w_ctr        = r_bht[w_upd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out  <= 1'b0;
      r_branch     <= 1'b0;
      r_target     <= '0;
      r_mispredict <= 1'b0;
    end else begin
      r_valid_out  <= bus.valid_in;
      r_branch     <= w_taken;
      r_target     <= w_target;
      r_mispredict <= w_mispredict;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (w_bht_upd) begin
      if (w_cond && w_ctr != 2'b11)       r_bht[w_upd_idx] <= w_ctr + 2'b01;
      else if (!w_cond && w_ctr != 2'b00) r_bht[w_upd_idx] <= w_ctr - 2'b01;
    end
  end

  // Read-before-write: the lookup sees the counter as it was before this edge.
  assign bus.pred_taken     = r_bht[w_rd_idx][1];
  assign bus.valid_out      = r_valid_out;
  assign bus.branch         = r_branch;
  assign bus.target_address = r_target;
  assign bus.mispredict     = r_mispredict;

  // Address bits above the BHT index and immediate bits above ADDR_W do not matter here.
  logic w_unused_bits;
  if (IMM_W > ADDR_W) begin : g_imm_hi
    assign w_unused_bits = ^{bus.imm[IMM_W-1:ADDR_W], bus.address[ADDR_W-1:IDX_W],
                             bus.fetch_addr[ADDR_W-1:IDX_W]};
  end else begin : g_imm_eq
    assign w_unused_bits = ^{bus.address[ADDR_W-1:IDX_W], bus.fetch_addr[ADDR_W-1:IDX_W]};
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [15:0] r_resolved_count;
  logic [15:0] r_mispredict_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resolved_count   <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (bus.valid_in && (bus.b || bus.j) && r_resolved_count != 16'hFFFF)
        r_resolved_count <= r_resolved_count + 16'd1;
      if (w_mispredict && r_mispredict_count != 16'hFFFF)
        r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  assign bus.resolved_count   = r_resolved_count;
  assign bus.mispredict_count = r_mispredict_count;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector bench for branch_predict_unit: resolve table plus BHT/reset sequences.
module tb_branch_predict_unit;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  branch_predict_unit_if #(.XLEN(32), .ADDR_W(10), .IMM_W(20)) bus ();

  branch_predict_unit #(.XLEN(32), .ADDR_W(10), .IMM_W(20), .BHT_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        b;
    logic        j;
    logic [2:0]  f3;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [9:0]  addr;
    logic [19:0] imm;
    logic        pred;
    logic        e_valid;
    logic        e_branch;
    logic [9:0]  e_target;
    logic        e_misp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic bb, input logic jj, input logic [2:0] f3,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [9:0] addr,
                       input logic [19:0] imm, input logic pred);
    bus.valid_in = v;
    bus.b        = bb;
    bus.j        = jj;
    bus.funct3   = f3;
    bus.op0      = a0;
    bus.op1      = a1;
    bus.address  = addr;
    bus.imm      = imm;
    bus.pred_in  = pred;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 10'd0, 20'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // BEQ at address with equal (taken) or unequal (not taken) operands.
  task automatic beq(input logic [9:0] addr, input logic taken);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'd7, taken ? 32'd7 : 32'd8, addr, 20'd0, 1'b0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.fetch_addr = 10'd0;
    idle();

    //           v  b  j  f3      op0           op1           addr     imm       pred  ev eb  etgt     em
    vecs[0]  = '{1, 1, 0, 3'b100, 32'hFFFFFFFF, 32'd1,        10'd10,  20'd4,    0,    1, 1, 10'd14,  1};
    vecs[1]  = '{1, 1, 0, 3'b110, 32'hFFFFFFFF, 32'd1,        10'd10,  20'd4,    0,    1, 0, 10'd14,  0};
    vecs[2]  = '{1, 1, 0, 3'b000, 32'd5,        32'd5,        10'd20,  20'hFFFFC,1,    1, 1, 10'd16,  0};
    vecs[3]  = '{1, 1, 0, 3'b001, 32'd5,        32'd5,        10'd20,  20'd8,    1,    1, 0, 10'd28,  1};
    vecs[4]  = '{1, 1, 0, 3'b101, 32'd1,        32'hFFFFFFFF, 10'd100, 20'd0,    0,    1, 1, 10'd100, 1};
    vecs[5]  = '{1, 1, 0, 3'b111, 32'd1,        32'hFFFFFFFF, 10'd5,   20'd1,    0,    1, 0, 10'd6,   0};
    vecs[6]  = '{1, 1, 0, 3'b011, 32'd9,        32'd9,        10'd7,   20'd2,    1,    1, 0, 10'd9,   1};
    vecs[7]  = '{0, 1, 0, 3'b000, 32'd9,        32'd9,        10'd50,  20'd3,    1,    0, 0, 10'd53,  0};
    vecs[8]  = '{1, 0, 0, 3'b000, 32'd9,        32'd9,        10'd1,   20'd1,    1,    1, 0, 10'd2,   0};
    vecs[9]  = '{1, 1, 1, 3'b010, 32'd1,        32'd2,        10'h3FE, 20'hFFFFC,1,    1, 1, 10'h3FA, 0};
    vecs[10] = '{1, 1, 0, 3'b100, 32'hFFFFFFFB, 32'hFFFFFFFD, 10'd0,   20'h003FF,1,    1, 1, 10'h3FF, 0};
    vecs[11] = '{1, 0, 1, 3'b000, 32'd0,        32'd0,        10'h3FF, 20'd1,    0,    1, 1, 10'd0,   1};

    do_reset();
    bus.fetch_addr = 10'd5;
    #1;
    check("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    check("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("rst_branch", {31'd0, bus.branch}, 32'd0);
    check("rst_target", {22'd0, bus.target_address}, 32'd0);
    check("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].b, vecs[i].j, vecs[i].f3, vecs[i].op0, vecs[i].op1,
            vecs[i].addr, vecs[i].imm, vecs[i].pred);
      step();
      check($sformatf("v%0d_valid_out", i), {31'd0, bus.valid_out}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_branch", i), {31'd0, bus.branch}, {31'd0, vecs[i].e_branch});
      check($sformatf("v%0d_target", i), {22'd0, bus.target_address}, {22'd0, vecs[i].e_target});
      check($sformatf("v%0d_mispredict", i), {31'd0, bus.mispredict}, {31'd0, vecs[i].e_misp});
    end
    idle();
    step();
    check("idle_valid_out", {31'd0, bus.valid_out}, 32'd0);

    // Saturation and read-before-write on index 3.
    do_reset();
    bus.fetch_addr = 10'd3;
    beq(10'd3, 1'b1);
    #1;
    check("ctr3_same_cycle_pre", {31'd0, bus.pred_taken}, 32'd0);
    step();
    check("ctr3_after_1", {31'd0, bus.pred_taken}, 32'd1);
    step();
    step();
    step();
    check("ctr3_after_4", {31'd0, bus.pred_taken}, 32'd1);
    beq(10'd3, 1'b0);
    step();
    check("ctr3_sat_dec1", {31'd0, bus.pred_taken}, 32'd1);
    step();
    check("ctr3_sat_dec2", {31'd0, bus.pred_taken}, 32'd0);
    step();
    step();
    step();
    beq(10'd3, 1'b1);
    #1;
    check("ctr3_pre_after_floor", {31'd0, bus.pred_taken}, 32'd0);
    step();
    check("ctr3_floor_inc", {31'd0, bus.pred_taken}, 32'd0);
    idle();

    // A jump at 0x3FE (index 14) must leave counter 14 untouched.
    bus.fetch_addr = 10'd14;
    beq(10'd14, 1'b1);
    step();
    check("ctr14_weak_t", {31'd0, bus.pred_taken}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'd1, 32'd2, 10'h3FE, 20'hFFFFC, 1'b1);
    step();
    check("jmp_target_wrap", {22'd0, bus.target_address}, 32'h3FA);
    check("jmp_branch", {31'd0, bus.branch}, 32'd1);
    check("ctr14_after_jmp", {31'd0, bus.pred_taken}, 32'd1);
    beq(10'd14, 1'b0);
    step();
    check("ctr14_after_nt", {31'd0, bus.pred_taken}, 32'd0);

    // A request sampled during reset is dropped.
    beq(10'd3, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    bus.fetch_addr = 10'd3;
    #1;
    check("rst_drop_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("rst_drop_branch", {31'd0, bus.branch}, 32'd0);
    beq(10'd3, 1'b1);
    step();
    check("rst_drop_ctr3", {31'd0, bus.pred_taken}, 32'd1);
    idle();

`ifdef BRANCH_PREDICT_STATS_EN
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 10'd4, 20'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 10'd4, 20'd0, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'd1, 32'd1, 10'd4, 20'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 10'd4, 20'd0, 1'b1);
    step();
    idle();
    step();
    check("stat_resolved", {16'd0, bus.resolved_count}, 32'd3);
    check("stat_mispredict", {16'd0, bus.mispredict_count}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stat_resolved_rst", {16'd0, bus.resolved_count}, 32'd0);
    check("stat_mispredict_rst", {16'd0, bus.mispredict_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
